// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the RV32 datapath (slave).
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      ins;
  logic             zero;
  logic             mem_ready;
  logic [2:0]       state;
  logic             ir_load;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             reg_write;
  logic [1:0]       wb_sel;
  logic             alu_src;
  logic [2:0]       alu_op;
  logic             mem_read;
  logic             mem_write;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  ins, zero, mem_ready,
    output state, ir_load, pc_write, pc_src, reg_write, wb_sel,
           alu_src, alu_op, mem_read, mem_write, illegal, retired
  );

  modport slave (
    output ins, zero, mem_ready,
    input  state, ir_load, pc_write, pc_src, reg_write, wb_sel,
           alu_src, alu_op, mem_read, mem_write, illegal, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB controller for the RV32 subset datapath.
// Strobes are decoded from state plus latched fields; a sticky TRAP catches unsupported encodings.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input logic              clk,
  input logic              reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t           st;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             f7b5;
  logic             illegal_r;
  logic [CNT_W-1:0] retired_r;

  // Returns {illegal, alu_op}; f7b5 only selects subtract for R-type add.
  function automatic logic [3:0] decode_alu(input logic [6:0] op, input logic [2:0] f3,
                                            input logic b5);
    logic       bad;
    logic [2:0] aop;
    bad = 1'b0;
    aop = 3'b000;
    case (op)
      OP_R, OP_I: begin
        case (f3)
          3'b000:  aop = (op == OP_R && b5) ? 3'b110 : 3'b010;
          3'b110:  aop = 3'b001;
          3'b111:  aop = 3'b000;
          3'b010:  aop = 3'b111;
          default: bad = 1'b1;
        endcase
      end
      OP_LW, OP_SW: aop = 3'b010;
      OP_BEQ:       aop = 3'b110;
      OP_JAL:       aop = 3'b000;
      default:      bad = 1'b1;
    endcase
    return {bad, aop};
  endfunction

  logic [3:0] dec;
  logic       is_lw, is_sw, is_beq, is_jal, uses_imm;
  logic       ir_load, pc_write, reg_write, alu_src, mem_read, mem_write;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] alu_op;

  assign dec      = decode_alu(opcode, funct3, f7b5);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_jal   = (opcode == OP_JAL);
  assign uses_imm = (opcode == OP_I) || is_lw || is_sw;

  // Output decode; reset suppresses every strobe so an aborted instruction has no side effects.
  always_comb begin
    ir_load   = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    alu_src   = 1'b0;
    alu_op    = 3'b000;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (!reset) begin
      case (st)
        S_FETCH: ir_load = 1'b1;
        S_EXEC: begin
          alu_op  = dec[2:0];
          alu_src = uses_imm;
          if (is_beq) begin
            pc_write = 1'b1;
            pc_src   = bus.zero ? 2'b01 : 2'b00;
          end
        end
        S_MEM: begin
          alu_op    = dec[2:0];
          alu_src   = uses_imm;
          mem_read  = is_lw;
          mem_write = is_sw;
          pc_write  = is_sw && bus.mem_ready;
        end
        S_WB: begin
          alu_op    = dec[2:0];
          alu_src   = uses_imm;
          reg_write = 1'b1;
          pc_write  = 1'b1;
          wb_sel    = is_lw ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
          pc_src    = is_jal ? 2'b10 : 2'b00;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= S_FETCH;
      opcode    <= '0;
      funct3    <= '0;
      f7b5      <= 1'b0;
      illegal_r <= 1'b0;
      retired_r <= '0;
    end else begin
      if (pc_write) retired_r <= retired_r + CNT_W'(1);
      case (st)
        S_FETCH: begin
          opcode <= bus.ins[6:0];
          funct3 <= bus.ins[14:12];
          f7b5   <= bus.ins[30];
          st     <= S_DECODE;
        end
        S_DECODE: begin
          if (dec[3]) begin
            st        <= S_TRAP;
            illegal_r <= 1'b1;
          end else begin
            st <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_lw || is_sw) st <= S_MEM;
          else if (is_beq)    st <= S_FETCH;
          else                st <= S_WB;
        end
        S_MEM: begin
          if (bus.mem_ready) st <= is_lw ? S_WB : S_FETCH;
        end
        S_WB:    st <= S_FETCH;
        S_TRAP:  st <= S_TRAP;
        default: st <= S_FETCH;
      endcase
    end
  end

  logic unused_ins;
  assign unused_ins = ^{bus.ins[31], bus.ins[29:15], bus.ins[11:7]};

  assign bus.state     = st;
  assign bus.ir_load   = ir_load;
  assign bus.pc_write  = pc_write;
  assign bus.pc_src    = pc_src;
  assign bus.reg_write = reg_write;
  assign bus.wb_sel    = wb_sel;
  assign bus.alu_src   = alu_src;
  assign bus.alu_op    = alu_op;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.illegal   = illegal_r;
  assign bus.retired   = retired_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expectations queued with the stimulus, popped at negedge.
module tb_multicycle_ctrl;

  localparam logic [31:0] JUNK = 32'h0000007F;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] exp_ret;

  multicycle_ctrl_if #(.CNT_W(32)) bus ();

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  st;
    logic        ir_load, pc_write, reg_write, mem_read, mem_write, illegal;
    logic [1:0]  pc_src, wb_sel;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic        chk_pcs, chk_wbs, chk_alu, chk_ill;
    logic [31:0] ret;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t base(input logic [2:0] s);
    exp_t e;
    e.st = s;
    e.ir_load = 1'b0; e.pc_write = 1'b0; e.reg_write = 1'b0;
    e.mem_read = 1'b0; e.mem_write = 1'b0; e.illegal = 1'b0;
    e.pc_src = 2'b00; e.wb_sel = 2'b00; e.alu_src = 1'b0; e.alu_op = 3'b000;
    e.chk_pcs = 1'b0; e.chk_wbs = 1'b0; e.chk_alu = 1'b0; e.chk_ill = 1'b1;
    e.ret = exp_ret;
    return e;
  endfunction

  task automatic push(input exp_t e);
    sb.push_back(e);
    if (e.pc_write) exp_ret = exp_ret + 32'd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic compare(input string t);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", t);
      return;
    end
    e = sb.pop_front();
    chk({t, ".state"},     32'(bus.state),     32'(e.st));
    chk({t, ".ir_load"},   32'(bus.ir_load),   32'(e.ir_load));
    chk({t, ".pc_write"},  32'(bus.pc_write),  32'(e.pc_write));
    chk({t, ".reg_write"}, 32'(bus.reg_write), 32'(e.reg_write));
    chk({t, ".mem_read"},  32'(bus.mem_read),  32'(e.mem_read));
    chk({t, ".mem_write"}, 32'(bus.mem_write), 32'(e.mem_write));
    chk({t, ".retired"},   bus.retired,        e.ret);
    if (e.chk_ill) chk({t, ".illegal"}, 32'(bus.illegal), 32'(e.illegal));
    if (e.chk_pcs) chk({t, ".pc_src"},  32'(bus.pc_src),  32'(e.pc_src));
    if (e.chk_wbs) chk({t, ".wb_sel"},  32'(bus.wb_sel),  32'(e.wb_sel));
    if (e.chk_alu) begin
      chk({t, ".alu_op"},  32'(bus.alu_op),  32'(e.alu_op));
      chk({t, ".alu_src"}, 32'(bus.alu_src), 32'(e.alu_src));
    end
  endtask

  task automatic tick(input string t, input logic [31:0] i, input logic z, input logic r,
                      input logic rs);
    @(posedge clk);
    #1;
    bus.ins       = i;
    bus.zero      = z;
    bus.mem_ready = r;
    reset         = rs;
    @(negedge clk);
    compare(t);
  endtask

  task automatic fetch_dec(input string t, input logic [31:0] w);
    exp_t e;
    e = base(3'd0); e.ir_load = 1'b1; push(e); tick({t, ".fetch"}, w, 1'b0, 1'b1, 1'b0);
    e = base(3'd1); push(e); tick({t, ".decode"}, JUNK, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic alu_instr(input string t, input logic [31:0] w, input logic [2:0] op,
                           input logic src);
    exp_t e;
    fetch_dec(t, w);
    e = base(3'd2); e.chk_alu = 1'b1; e.alu_op = op; e.alu_src = src;
    push(e); tick({t, ".exec"}, JUNK, 1'b1, 1'b1, 1'b0);
    e = base(3'd4); e.chk_alu = 1'b1; e.alu_op = op; e.alu_src = src;
    e.reg_write = 1'b1; e.pc_write = 1'b1;
    e.chk_pcs = 1'b1; e.pc_src = 2'b00; e.chk_wbs = 1'b1; e.wb_sel = 2'b00;
    push(e); tick({t, ".wb"}, JUNK, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic beq_instr(input string t, input logic z);
    exp_t e;
    fetch_dec(t, 32'h00208463);
    e = base(3'd2); e.chk_alu = 1'b1; e.alu_op = 3'b110; e.alu_src = 1'b0;
    e.pc_write = 1'b1; e.chk_pcs = 1'b1; e.pc_src = z ? 2'b01 : 2'b00;
    push(e); tick({t, ".exec"}, JUNK, z, 1'b1, 1'b0);
  endtask

  initial begin
    exp_t e;
    checks        = 0;
    errors        = 0;
    exp_ret       = 32'd0;
    reset         = 1'b1;
    bus.ins       = 32'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);

    // Reset: FETCH, no strobes, counters clear
    e = base(3'd0); push(e); tick("reset", 32'h002081B3, 1'b1, 1'b1, 1'b1);

    alu_instr("add",  32'h002081B3, 3'b010, 1'b0);
    alu_instr("sub",  32'h402081B3, 3'b110, 1'b0);
    alu_instr("slt",  32'h0020A1B3, 3'b111, 1'b0);
    alu_instr("addi", 32'h00508093, 3'b010, 1'b1);
    alu_instr("addi_b30", 32'h40008093, 3'b010, 1'b1);
    alu_instr("ori",  32'h0000E093, 3'b001, 1'b1);
    alu_instr("andi", 32'h0000F093, 3'b000, 1'b1);

    // lw with three not-ready MEM cycles; mem_ready high before MEM must be ignored
    fetch_dec("lw", 32'h0000A283);
    e = base(3'd2); e.chk_alu = 1'b1; e.alu_op = 3'b010; e.alu_src = 1'b1;
    push(e); tick("lw.exec", JUNK, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      e = base(3'd3); e.mem_read = 1'b1; e.chk_alu = 1'b1; e.alu_op = 3'b010; e.alu_src = 1'b1;
      push(e); tick("lw.mem_wait", JUNK, 1'b0, 1'b0, 1'b0);
    end
    e = base(3'd3); e.mem_read = 1'b1; e.chk_alu = 1'b1; e.alu_op = 3'b010; e.alu_src = 1'b1;
    push(e); tick("lw.mem_done", JUNK, 1'b0, 1'b1, 1'b0);
    e = base(3'd4); e.reg_write = 1'b1; e.pc_write = 1'b1; e.chk_wbs = 1'b1; e.wb_sel = 2'b01;
    e.chk_pcs = 1'b1; e.pc_src = 2'b00; e.chk_alu = 1'b1; e.alu_op = 3'b010; e.alu_src = 1'b1;
    push(e); tick("lw.wb", JUNK, 1'b0, 1'b0, 1'b0);

    // sw completing on the first MEM cycle
    fetch_dec("sw", 32'h0050A223);
    e = base(3'd2); e.chk_alu = 1'b1; e.alu_op = 3'b010; e.alu_src = 1'b1;
    push(e); tick("sw.exec", JUNK, 1'b0, 1'b0, 1'b0);
    e = base(3'd3); e.mem_write = 1'b1; e.pc_write = 1'b1; e.chk_pcs = 1'b1; e.pc_src = 2'b00;
    e.chk_alu = 1'b1; e.alu_op = 3'b010; e.alu_src = 1'b1;
    push(e); tick("sw.mem", JUNK, 1'b0, 1'b1, 1'b0);

    beq_instr("beq_taken", 1'b1);
    beq_instr("beq_not_taken", 1'b0);

    fetch_dec("jal", 32'h010000EF);
    e = base(3'd2); push(e); tick("jal.exec", JUNK, 1'b0, 1'b1, 1'b0);
    e = base(3'd4); e.reg_write = 1'b1; e.pc_write = 1'b1; e.chk_wbs = 1'b1; e.wb_sel = 2'b10;
    e.chk_pcs = 1'b1; e.pc_src = 2'b10;
    push(e); tick("jal.wb", JUNK, 1'b0, 1'b1, 1'b0);

    // Unsupported opcode: sticky TRAP, retired frozen, then reset recovers
    fetch_dec("trap_op", 32'h0000007F);
    for (int k = 0; k < 11; k++) begin
      e = base(3'd5); e.illegal = 1'b1;
      push(e); tick("trap_op.hold", 32'h002081B3, 1'b1, 1'b1, 1'b0);
    end
    e = base(3'd5); e.chk_ill = 1'b0; push(e); tick("trap_op.reset", JUNK, 1'b0, 1'b0, 1'b1);
    exp_ret = 32'd0;

    // Unsupported R-type funct3 also traps
    fetch_dec("trap_f3", 32'h002091B3);
    e = base(3'd5); e.illegal = 1'b1; push(e); tick("trap_f3.hold", JUNK, 1'b0, 1'b0, 1'b0);
    e = base(3'd5); e.chk_ill = 1'b0; push(e); tick("trap_f3.reset", JUNK, 1'b0, 1'b0, 1'b1);
    exp_ret = 32'd0;

    alu_instr("add2", 32'h002081B3, 3'b010, 1'b0);

    // Reset during lw MEM wait aborts without write-back or PC update
    fetch_dec("lw_abort", 32'h0000A283);
    e = base(3'd2); e.chk_alu = 1'b1; e.alu_op = 3'b010; e.alu_src = 1'b1;
    push(e); tick("lw_abort.exec", JUNK, 1'b0, 1'b0, 1'b0);
    e = base(3'd3); e.mem_read = 1'b1; push(e); tick("lw_abort.mem", JUNK, 1'b0, 1'b0, 1'b0);
    e = base(3'd3); push(e); tick("lw_abort.reset", JUNK, 1'b0, 1'b1, 1'b1);
    exp_ret = 32'd0;

    alu_instr("add3", 32'h002081B3, 3'b010, 1'b0);
    e = base(3'd0); e.ir_load = 1'b1; push(e); tick("final.fetch", 32'h002081B3, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
